// File: rtl/muldiv_defs.sv
// Shared definitions for the EX-stage RV32M multiply/divide unit: funct3 codes,
// FSM state encoding, iteration count and special-case divide constants.
package muldiv_defs;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int          ITER_COUNT    = 32;
  localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [31:0] SIGNED_MIN    = 32'h8000_0000;

  // MULHSU is the only op whose operands differ in signedness.
  function automatic logic rs1_is_signed(input logic [2:0] f3);
    return !(f3 == F3_MULHU || f3 == F3_DIVU || f3 == F3_REMU);
  endfunction

  function automatic logic rs2_is_signed(input logic [2:0] f3);
    return f3 == F3_MUL || f3 == F3_MULH || f3 == F3_DIV || f3 == F3_REM;
  endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// One restoring radix-2 division step: shift the next dividend bit into the
// partial remainder and subtract the divisor when it fits.
module muldiv_div_step #(
  parameter int W = 32
) (
  input  logic [W:0]   rem,
  input  logic         dividend_bit,
  input  logic [W-1:0] divisor,
  output logic [W:0]   rem_next,
  output logic         q_bit
);

  logic [W+1:0] shifted;

  assign shifted  = {rem, dividend_bit};
  assign q_bit    = (shifted >= {2'b00, divisor});
  assign rem_next = q_bit ? (shifted[W:0] - {1'b0, divisor}) : shifted[W:0];

endmodule

// File: rtl/ex_muldiv_unit.sv
// Multi-cycle RV32M multiply/divide unit for the EX stage; stalls the pipeline
// via busy_o. Define MULDIV_FAST_MUL_EN for a single-cycle multiplier.
module ex_muldiv_unit
  import muldiv_defs::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic            flush_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

`ifdef MULDIV_FAST_MUL_EN
  localparam state_e MUL_ENTRY = ST_DONE;
`else
  localparam state_e MUL_ENTRY = ST_MUL;
`endif

  state_e          state_q, state_d;
  logic [2:0]      funct3_q;
  logic [XLEN-1:0] opa_q, opb_q, result_q;
  logic [XLEN:0]   acc_q;
  logic [5:0]      cnt_q;
  logic            neg_res_q, neg_rem_q;

  logic            accept, sign_a, sign_b, last_iter;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_by_zero, div_ovf, special;
  logic [XLEN-1:0] special_res;

  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_prod, mul_prod_s;
  logic [XLEN-1:0]   mul_res;

  logic [XLEN:0]   div_rem;
  logic            div_qbit;
  logic [XLEN-1:0] div_quot, div_res;

  assign accept    = (state_q == ST_IDLE) && start_i && !flush_i;
  assign sign_a    = rs1_is_signed(funct3_i) && rs1_i[XLEN-1];
  assign sign_b    = rs2_is_signed(funct3_i) && rs2_i[XLEN-1];
  assign a_mag     = sign_a ? -rs1_i : rs1_i;
  assign b_mag     = sign_b ? -rs2_i : rs2_i;
  assign last_iter = (cnt_q == 6'(ITER_COUNT - 1));

  assign div_by_zero = (rs2_i == '0);
  assign div_ovf     = (funct3_i == F3_DIV || funct3_i == F3_REM) &&
                       (rs1_i == SIGNED_MIN) && (rs2_i == '1);
  assign special     = funct3_i[2] && (div_by_zero || div_ovf);
  assign special_res = div_by_zero ? (funct3_i[1] ? rs1_i : DIV_BY_ZERO_Q)
                                   : (funct3_i[1] ? '0    : SIGNED_MIN);

`ifdef MULDIV_FAST_MUL_EN
  // Sign-extended 64-bit operands give the exact 33x33 signed product modulo 2^64.
  logic [2*XLEN-1:0] fast_a, fast_b, fast_prod;
  logic [XLEN-1:0]   fast_res;

  assign fast_a    = {{XLEN{sign_a}}, rs1_i};
  assign fast_b    = {{XLEN{sign_b}}, rs2_i};
  assign fast_prod = fast_a * fast_b;
  assign fast_res  = (funct3_i == F3_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
`endif

  // Shift-add: acc holds the product high half, opb shifts the multiplier out
  // while the product low half shifts in.
  assign mul_sum    = acc_q + (opb_q[0] ? {1'b0, opa_q} : '0);
  assign mul_prod   = {mul_sum, opb_q[XLEN-1:1]};
  assign mul_prod_s = neg_res_q ? -mul_prod : mul_prod;
  assign mul_res    = (funct3_q == F3_MUL) ? mul_prod_s[XLEN-1:0] : mul_prod_s[2*XLEN-1:XLEN];

  muldiv_div_step #(.W(XLEN)) u_div_step (
    .rem          (acc_q),
    .dividend_bit (opa_q[XLEN-1]),
    .divisor      (opb_q),
    .rem_next     (div_rem),
    .q_bit        (div_qbit)
  );

  assign div_quot = {opa_q[XLEN-2:0], div_qbit};
  assign div_res  = funct3_q[1] ? (neg_rem_q ? -div_rem[XLEN-1:0] : div_rem[XLEN-1:0])
                                : (neg_res_q ? -div_quot : div_quot);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: state_d gets its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (funct3_i[2]) state_d = special ? ST_DONE : ST_DIV;
          else             state_d = MUL_ENTRY;
        end
      end
      ST_MUL, ST_DIV: if (last_iter) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (flush_i) state_d = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      funct3_q  <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
    end else if (flush_i) begin
      cnt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            funct3_q  <= funct3_i;
            opa_q     <= a_mag;
            opb_q     <= b_mag;
            acc_q     <= '0;
            cnt_q     <= '0;
            neg_res_q <= sign_a ^ sign_b;
            neg_rem_q <= sign_a;
            if (special) result_q <= special_res;
`ifdef MULDIV_FAST_MUL_EN
            if (!funct3_i[2]) result_q <= fast_res;
`endif
          end
        end
        ST_MUL: begin
          acc_q <= {1'b0, mul_sum[XLEN:1]};
          opb_q <= {mul_sum[0], opb_q[XLEN-1:1]};
          cnt_q <= cnt_q + 6'd1;
          if (last_iter) result_q <= mul_res;
        end
        ST_DIV: begin
          acc_q <= div_rem;
          opa_q <= div_quot;
          cnt_q <= cnt_q + 6'd1;
          if (last_iter) result_q <= div_res;
        end
        default: ;
      endcase
    end
  end

  // The accept term is gated by rst_n so a held start_i cannot raise a stall in reset.
  assign busy_o   = rst_n && (accept || state_q == ST_MUL || state_q == ST_DIV);
  assign done_o   = (state_q == ST_DONE) && !flush_i;
  assign result_o = result_q;

endmodule

// File: doc/ex_muldiv_unit.md
# ex_muldiv_unit

Multi-cycle RV32M multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register. It accepts forwarded operands and `funct3` for M-extension instructions, then raises `busy_o` to the hazard unit so that PC, IF/ID and ID/EX hold. It delivers a 32-bit result for one cycle with `done_o` set, and the result goes to the EX/MEM register through the EX result mux.

## Interface
- `XLEN`, default 32: operand and result width; only 32 is supported.
- `clk` input 1: clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `start_i` input 1: the EX-stage instruction is an M-extension op (ID/EX outputs already qualified).
- `flush_i` input 1: kills any in-flight operation (branch mispredict / ID/EX flush).
- `funct3_i` input 3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `rs1_i` input 32: operand A, post-forwarding.
- `rs2_i` input 32: operand B, post-forwarding.
- `busy_o` output 1: stall request to the hazard unit.
- `done_o` output 1: `result_o` is valid this cycle.
- `result_o` output 32: registered result.

## Operation
- States: `IDLE`, `MUL`, `DIV`, `DONE`.
- **Accept.** In `IDLE`, `start_i`=1 and `flush_i`=0:
  - latch `funct3`;
  - latch operand magnitudes, using two's-complement absolute value for signed operands;
  - latch the result-negate flag;
  - clear the 6-bit iteration counter.
- **Transitions from IDLE:**
  - `funct3[2]`=0 goes to `MUL`;
  - `funct3[2]`=1 goes to `DIV`;
  - a special divide case goes straight to `DONE`.
- **Signedness:**
  - MUL, MULH, DIV, REM treat both operands as signed;
  - MULHSU treats rs1 as signed and rs2 as unsigned;
  - MULHU, DIVU, REMU treat both as unsigned.
- **MUL.** Shift-add over a 64-bit product, one bit per cycle, 32 iterations. After the last iteration:
  - negate the 64-bit product if the negate flag is set;
  - MUL takes `product[31:0]`; the MULH variants take `product[63:32]`.
  - The state then goes to `DONE`.
- **DIV.** Restoring radix-2 division with a 33-bit partial remainder, 32 iterations.
  - Quotient sign = sign(A) XOR sign(B).
  - Remainder sign = sign(A).
  - The state then goes to `DONE`.
- **Special divide cases** are decided in the accept cycle with no iteration:
  - divisor 0: DIV/DIVU return 0xFFFFFFFF; REM/REMU return rs1;
  - DIV with 0x80000000 / 0xFFFFFFFF: returns 0x80000000; REM of the same operands returns 0.
- **DONE:**
  - `done_o`=1 and `busy_o`=0 for exactly one cycle, so the pipeline advances;
  - `start_i` is ignored in this cycle, because it still reflects the same held instruction;
  - next state is always `IDLE`.
- **busy_o** = (`IDLE` & `start_i` & !`flush_i`) | `MUL` | `DIV`. It is combinational so the stall takes effect in the start cycle.
- **Flush.** `flush_i`=1 in any state:
  - next state is `IDLE`;
  - the counter is cleared;
  - `done_o` is not asserted;
  - `result_o` keeps its previous value.
- **Reset:**
  - state `IDLE`, counter 0;
  - `result_o`=0, `done_o`=0, `busy_o`=0;
  - all operand and accumulator registers are 0.

## Timing
- Cycle 0 is the accept cycle (`busy_o`=1).
- Iterative MUL/DIV: iteration cycles 1–32 (`busy_o`=1); `DONE` in cycle 33 with `done_o`=1. Latency is 33 cycles and the pipeline stalls for 33 cycles.
- Special divide case: `DONE` in cycle 1. Latency 1, stall 1 cycle.
- Back-to-back M ops: the second op is accepted in the cycle after `DONE`; there is no bubble beyond the `DONE` cycle.
- Flush in the accept cycle: `busy_o` is 0 in that cycle and no operation starts.
- Reset asserted mid-operation: all outputs go to their reset values immediately and asynchronously.

## Configuration
- `MULDIV_FAST_MUL_EN` defined:
  - MUL* uses a single-cycle 33x33 signed combinational multiplier;
  - accept goes directly to `DONE`, giving latency 1;
  - the `MUL` state is unused.
- `MULDIV_FAST_MUL_EN` undefined: iterative 32-cycle multiplier as described above.
- Divide is always iterative.

## Structure
- Shared package `muldiv_defs`, which holds:
  - the eight `funct3` encodings;
  - the state encodings (2-bit);
  - `ITER_COUNT` = 32;
  - the special-case constants `DIV_BY_ZERO_Q` = 0xFFFFFFFF and `SIGNED_MIN` = 0x80000000.
- Sub-module `muldiv_div_step`: combinational single restoring-division step (partial remainder, dividend bit, divisor → next remainder, quotient bit), instantiated once.

## Test plan
- **MUL:** MUL 7 x -3 → `result_o`=0xFFFFFFEB, `done_o` at cycle 33 (cycle 1 with `MULDIV_FAST_MUL_EN`); `busy_o` high in cycles 0–32.
- **High multiplies:** MULH, MULHSU, MULHU with 0xFFFFFFFF x 0xFFFFFFFF → 0x00000000, 0xFFFFFFFF, 0xFFFFFFFE respectively.
- **Signed divide:** DIV -20/3 → 0xFFFFFFFA; REM -20/3 → 0xFFFFFFFE; DIVU 20/3 → 6; all with `done_o` at cycle 33.
- **Special cases:**
  - DIV 5/0 → 0xFFFFFFFF; REMU 5/0 → 5;
  - DIV 0x80000000 / -1 → 0x80000000; REM of the same → 0;
  - each completes in 1 cycle.
- **Flush mid-divide:** `flush_i` at cycle 10 → `IDLE` at cycle 11, `busy_o`=0, no `done_o`; the next DIV runs the full 33 cycles with a correct result.
- **Reset and back-to-back:** `rst_n` pulsed low at cycle 15 of a MUL → outputs 0 at once. After release, two back-to-back MULs with `start_i` held through `DONE` → exactly two `done_o` pulses.
